delay_meter: RTL and testbench
==============================

# delay_meter

Clocked measurement stage wrapped around a `delay_1b` inverter-chain delay line in `async_lib`.
- Drives the delay line's input and captures its output through a synchronizer.
- Counts clock cycles from each launched transition until that transition returns.
- Repeats over several runs and reports the sum and maximum of the counts.
- Software uses the results to calibrate `INVERTER_PER_NS` and to check bundled-data delay margins on silicon/FPGA.

## Interface

Parameters:
- `CNT_W`, 16: width of the per-run cycle counter.
- `TIMEOUT`, 4095: per-run cycle limit; must be < 2**CNT_W.
- `RUNS_LOG2`, 2: number of runs per measurement is 2**RUNS_LOG2.
- `SYNC_STAGES`, 2: synchronizer depth on `probe_in`; minimum 2.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request a measurement; sampled only in IDLE.
- `probe_out`  out  1  registered; drives the delay line `data_in`.
- `probe_in`  in  1  asynchronous; from the delay line `data_out`.
- `busy`  out  1  high from the accepted start until done.
- `done`  out  1  one-cycle pulse at the end of a measurement.
- `timeout`  out  1  measurement aborted; held until the next accepted start.
- `result_sum`  out  CNT_W+RUNS_LOG2  sum of per-run counts.
- `result_max`  out  CNT_W  largest per-run count.

## Operation

- FSM states: IDLE, LAUNCH, WAIT, SETTLE, DONE.
- **IDLE:**
  - `start`=1 → LAUNCH.
  - On entry to LAUNCH, clear `result_sum`, `result_max`, `timeout` and the run index.
- **LAUNCH (1 cycle):**
  - Toggle `probe_out`.
  - Capture the synchronized `probe_in` into `ref`.
  - Clear `cnt`.
  - → WAIT.
- **WAIT:**
  - Each cycle with synced == `ref`: `cnt`++.
  - First cycle with synced != `ref`:
    - `result_sum` += `cnt` (zero-extended).
    - `result_max` = max(`result_max`, `cnt`).
    - → SETTLE.
  - Comparing against `ref` makes the block independent of the chain's inversion parity.
- **Timeout:** if `cnt` == `TIMEOUT` while still waiting:
  - Set `timeout`.
  - → DONE.
  - `result_sum`/`result_max` keep the completed runs only.
- **SETTLE:**
  - Wait SYNC_STAGES+2 cycles so the synchronizer is quiet.
  - Then, if runs remain, increment the run index and → LAUNCH; otherwise → DONE.
- **Edge polarity:** consecutive runs alternate rising and falling launches, so both edge polarities are measured.
- **DONE (1 cycle):** `done`=1, `busy` drops, → IDLE.
- **`start` handling:**
  - `start` outside IDLE is ignored.
  - `start` held high re-triggers a new measurement the cycle after DONE.
- **Counter:** saturation is unnecessary because `TIMEOUT` < 2**CNT_W.
- **Reset, including mid-measurement:**
  - Next state IDLE.
  - `probe_out`=0, `busy`=0, `done`=0, `timeout`=0, `result_sum`=0, `result_max`=0.
  - Synchronizer flops cleared to 0.

## Timing

- `probe_out` toggles on the clock edge that ends LAUNCH (call it E0).
- With a zero-delay loopback (`probe_in` = `probe_out`), a run counts exactly SYNC_STAGES.
- A loopback delayed by k whole cycles counts SYNC_STAGES+k.
- Sub-cycle delays give SYNC_STAGES+ceil(d/Tclk) with ±1 cycle uncertainty.
- Per-run latency: 1 (LAUNCH) + cnt+1 (WAIT) + SYNC_STAGES+2 (SETTLE).
- `done` rises one cycle after the last SETTLE, or one cycle after the timeout detection cycle.
- `result_*` are stable and valid whenever `done`=1 and remain held in IDLE.
- `busy` is 1 from the cycle after the accepted `start` through the cycle before `done`.

## Structure

- **Package `delay_meter_pkg`:** the state typedef `delay_meter_state_e`, and the localparam for SETTLE length (SYNC_STAGES+2) as a function of SYNC_STAGES.
- **Sub-module `sync_ff`:**
  - Parameterized-depth flop synchronizer with synchronous active-high reset to 0.
  - Placed in `async_lib` for reuse by other async/sync boundaries.
- **Integration:** `delay_1b` is not instantiated inside this block. The top-level connects `probe_out` → `data_in` and `data_out` → `probe_in`.

## Test plan

- **Zero-delay loopback**, defaults, pulse `start`:
  - Four runs of 2 each → `result_sum`=8, `result_max`=2, `timeout`=0.
  - `done` pulses once; `probe_out` ends at 0 after four toggles.
- **Bench delay model of 5 cycles on the loop:**
  - `result_sum`=28, `result_max`=7.
  - Repeat with an inverting model: same results.
- **Asymmetric model** (rise 3 cycles, fall 6 cycles): `result_sum`=26, `result_max`=8.
- **Timeout:** `probe_in` tied to 0 with `TIMEOUT`=20:
  - First run times out → `timeout`=1, `result_sum`=0, `done` pulses.
  - Next `start` clears `timeout`.
- **Reset mid-measurement:** assert `rst` during WAIT of run 2:
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - A following `start` gives the clean loopback result (8 / 2).
- **`start` while busy:** pulse `start` during WAIT and SETTLE → no restart, single `done`, results unchanged from the undisturbed case.

Source files
------------

// File: rtl/delay_meter_pkg.sv
// Shared types and timing constants for the delay_meter measurement stage.
package delay_meter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        SETTLE,
        DONE
    } delay_meter_state_e;

    // Quiet cycles after a returned edge, on top of the synchronizer depth.
    localparam int unsigned SETTLE_EXTRA = 2;

    function automatic int unsigned settle_cycles(input int unsigned sync_stages);
        return sync_stages + SETTLE_EXTRA;
    endfunction

endpackage

// File: rtl/delay_meter_sync_ff.sv
// Flop-chain synchronizer (async_lib) with synchronous active-high reset to 0.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/delay_meter.sv
// Launches transitions into an external delay line and counts clock cycles
// until each returns; reports sum and maximum over 2**RUNS_LOG2 runs.
module delay_meter
    import delay_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 4095,
    parameter int unsigned RUNS_LOG2   = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      probe_out,
    input  logic                      probe_in,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [CNT_W+RUNS_LOG2-1:0] result_sum,
    output logic [CNT_W-1:0]          result_max
);

    localparam int unsigned       SUM_W       = CNT_W + RUNS_LOG2;
    localparam int unsigned       SETTLE_LEN  = settle_cycles(SYNC_STAGES);
    localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

    delay_meter_state_e   state;
    logic                 probe_sync;
    logic                 ref_lvl;
    logic [CNT_W-1:0]     cnt;
    logic [RUNS_LOG2-1:0] run_idx;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (probe_in),
        .q  (probe_sync)
    );

    // cnt is shared: run length in WAIT, quiet-cycle count in SETTLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            probe_out  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            result_sum <= '0;
            result_max <= '0;
            cnt        <= '0;
            run_idx    <= '0;
            ref_lvl    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LAUNCH;
                        busy       <= 1'b1;
                        timeout    <= 1'b0;
                        result_sum <= '0;
                        result_max <= '0;
                        run_idx    <= '0;
                    end
                end
                LAUNCH: begin
                    probe_out <= ~probe_out;
                    ref_lvl   <= probe_sync;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // Comparing against the pre-launch level keeps this
                    // independent of the delay line's inversion parity.
                    if (probe_sync != ref_lvl) begin
                        result_sum <= result_sum + SUM_W'(cnt);
                        if (cnt > result_max) begin
                            result_max <= cnt;
                        end
                        cnt   <= '0;
                        state <= SETTLE;
                    end else if (cnt == TIMEOUT_C) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        if (run_idx == '1) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            run_idx <= run_idx + 1'b1;
                            state   <= LAUNCH;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_meter.sv
// Directed bench for delay_meter: loop delay models around the probe pins.
module tb_delay_meter;
    import delay_meter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_t = 1'b0;
    logic        probe_out, probe_in;
    logic        busy, done, timeout;
    logic [17:0] result_sum;
    logic [15:0] result_max;
    logic        probe_out_t;
    logic        busy_t, done_t, timeout_t;
    logic [17:0] result_sum_t;
    logic [15:0] result_max_t;

    logic [7:0]  hist = '0;
    int          mode = 0;
    logic        sel = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        m_busy, m_done, m_timeout, m_probe;
    logic [17:0] m_sum;
    logic [15:0] m_max;

    always #5 clk = ~clk;

    delay_meter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start_a),
        .probe_out (probe_out),
        .probe_in  (probe_in),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .result_sum(result_sum),
        .result_max(result_max)
    );

    delay_meter #(.TIMEOUT(20)) dut_t (
        .clk       (clk),
        .rst       (rst),
        .start     (start_t),
        .probe_out (probe_out_t),
        .probe_in  (1'b0),
        .busy      (busy_t),
        .done      (done_t),
        .timeout   (timeout_t),
        .result_sum(result_sum_t),
        .result_max(result_max_t)
    );

    // Loop models: hist[k-1] is probe_out delayed by k whole cycles.
    always @(posedge clk) hist <= {hist[6:0], probe_out};

    always_comb begin
        case (mode)
            0:       probe_in = probe_out;
            1:       probe_in = hist[4];
            2:       probe_in = ~hist[4];
            3:       probe_in = hist[2] | hist[5];
            default: probe_in = 1'b0;
        endcase
    end

    assign m_busy    = sel ? busy_t       : busy;
    assign m_done    = sel ? done_t       : done;
    assign m_timeout = sel ? timeout_t    : timeout;
    assign m_probe   = sel ? probe_out_t  : probe_out;
    assign m_sum     = sel ? result_sum_t : result_sum;
    assign m_max     = sel ? result_max_t : result_max;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic measure(input string tag, input bit use_t, input bit poke,
                           input int exp_sum, input int exp_max, input int exp_to,
                           input int exp_busy, input int exp_po);
        int cyc, n_busy, n_extra;
        sel = use_t;
        @(negedge clk);
        if (use_t) start_t = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_t = 1'b0;
        start_a = 1'b0;
        check({tag, "_to_clr"}, 32'(m_timeout), 0);
        cyc = 0;
        n_busy = 0;
        while (!m_done && cyc < 2000) begin
            if (m_busy) n_busy++;
            start_a = poke && (cyc == 2 || cyc == 5);
            @(posedge clk); #1;
            cyc++;
        end
        start_a = 1'b0;
        check({tag, "_done_seen"}, 32'(m_done), 1);
        check({tag, "_busy_at_done"}, 32'(m_busy), 0);
        check({tag, "_busy_cycles"}, 32'(n_busy), 32'(exp_busy));
        check({tag, "_sum"}, 32'(m_sum), 32'(exp_sum));
        check({tag, "_max"}, 32'(m_max), 32'(exp_max));
        check({tag, "_timeout"}, 32'(m_timeout), 32'(exp_to));
        check({tag, "_probe_out"}, 32'(m_probe), 32'(exp_po));
        n_extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (m_done) n_extra++;
        end
        check({tag, "_extra_done"}, 32'(n_extra), 0);
        check({tag, "_sum_held"}, 32'(m_sum), 32'(exp_sum));
        check({tag, "_max_held"}, 32'(m_max), 32'(exp_max));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_probe_out", 32'(probe_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_sum", 32'(result_sum), 0);
        check("rst_max", 32'(result_max), 0);
        repeat (5) @(posedge clk);
        #1;

        // Per run: 1 LAUNCH + (cnt+1) WAIT + 4 SETTLE.
        mode = 0;
        measure("loop0", 1'b0, 1'b0, 8, 2, 0, 32, 0);

        mode = 1;
        repeat (10) @(posedge clk);
        #1;
        measure("dly5", 1'b0, 1'b0, 28, 7, 0, 52, 0);

        mode = 2;
        repeat (10) @(posedge clk);
        #1;
        measure("dly5inv", 1'b0, 1'b0, 28, 7, 0, 52, 0);

        mode = 3;
        repeat (10) @(posedge clk);
        #1;
        measure("asym", 1'b0, 1'b0, 26, 8, 0, 50, 0);

        measure("tmo1", 1'b1, 1'b0, 0, 0, 1, 22, 1);
        measure("tmo2", 1'b1, 1'b0, 0, 0, 1, 22, 0);

        // Reset during WAIT of the second run.
        mode = 0;
        sel = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_state_wait", 32'(dut.state), 32'(WAIT));
        check("mid_sum_run1", 32'(result_sum), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        check("mid_rst_probe_out", 32'(probe_out), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_timeout", 32'(timeout), 0);
        check("mid_rst_sum", 32'(result_sum), 0);
        check("mid_rst_max", 32'(result_max), 0);
        repeat (6) @(posedge clk);
        #1;
        measure("post_rst", 1'b0, 1'b0, 8, 2, 0, 32, 0);

        measure("start_busy", 1'b0, 1'b1, 8, 2, 0, 32, 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
